// File: rtl/instr_issuer_if.sv
// Host/Controller-facing bus of the instruction issuer: program load port,
// run control, and the issued instruction with its status flags.
interface instr_issuer_if #(
  parameter int ADDR_W = 6
) ();
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              run;
  logic [31:0]       instruction;
  logic              start;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, run,
    input  instruction, start, busy, done, error, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run,
    output instruction, start, busy, done, error, pc
  );
endinterface

// File: rtl/instr_issuer.sv
// Program buffer and sequencer for the bit-serial PE-array Controller: issues one
// instruction at a time and waits a fixed per-opcode latency. Optional STEP_MODE_EN.
module instr_issuer #(
  parameter int LENGTH     = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int MUL_CYCLES = (LENGTH + 1) * (2 * LENGTH + 4)
) (
  input  logic clk,
  input  logic reset,
`ifdef STEP_MODE_EN
  input  logic step,
`endif
  instr_issuer_if.slave bus
);

`ifdef STEP_MODE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_ADV, S_DONE, S_HOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_ADV, S_DONE
  } state_t;
`endif

  localparam logic [5:0] OP_HALT = 6'd63;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic [31:0]       instr_q, instr_d;
  logic [15:0]       wait_q, wait_d;
  logic [31:0]       rd_word_q;
  logic [5:0]        opcode;
  logic              start;
  logic              done;

  logic [31:0] mem [DEPTH];

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'd0, 6'd1, 6'd2, 6'd5, 6'd7, 6'd8, 6'd9, 6'd10: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] lat_of(input logic [5:0] op);
    case (op)
      6'd0, 6'd1, 6'd9, 6'd10: lat_of = 16'(2 * LENGTH + 2);
      6'd5, 6'd8:              lat_of = 16'(LENGTH + 3);
      6'd7:                    lat_of = 16'(LENGTH + 2);
      6'd2:                    lat_of = 16'(MUL_CYCLES);
      default:                 lat_of = 16'd0;
    endcase
  endfunction

  // Buffer is read every cycle at pc, so the word is ready in DECODE after FETCH.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_q) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
    rd_word_q <= mem[pc_q];
  end

  assign opcode = rd_word_q[31:26];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      instr_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
    end
  end

  // The ISSUE cycle counts as the first latency cycle, giving start-to-start = LAT+3.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    error_d = error_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
          pc_d    = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_DONE;
        end else if (is_legal(opcode)) begin
          instr_d = rd_word_q;
          wait_d  = lat_of(opcode);
          state_d = S_ISSUE;
        end else begin
          error_d = 1'b1;
          state_d = S_ADV;
        end
      end
      S_ISSUE: begin
        wait_d  = wait_q - 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 16'd1) begin
          state_d = S_ADV;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      S_ADV: begin
        if (pc_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
`ifdef STEP_MODE_EN
          state_d = S_HOLD;
`else
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
`endif
        end
      end
`ifdef STEP_MODE_EN
      S_HOLD: begin
        if (step) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_ISSUE: start = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  assign bus.instruction = instr_q;
  assign bus.start       = start;
  assign bus.busy        = busy_q;
  assign bus.done        = done;
  assign bus.error       = error_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: table of opcodes plus hand-written
// sequences; a scoreboard queue holds the expected issued instructions.
module tb_instr_issuer;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_issuer_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef STEP_MODE_EN
  logic step = 1'b0;
`endif

  instr_issuer #(.LENGTH(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef STEP_MODE_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  typedef struct { logic [31:0] word; int gap; } exp_t;
  typedef struct { logic [5:0] op; int gap; bit legal; } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          last_start = 0;
  int          n_started = 0;
  logic [31:0] cur_word = '0;
  logic [31:0] last_word = '0;
  bit          hold_bad = 0;
  bit          saw_nz = 0;
  bit          wrapped = 0;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'b0};
  endfunction

  // Scoreboard consumer: every start pulse pops one expected issue.
  always @(negedge clk) begin
    if (!reset && bus.busy) begin
      if (bus.pc != '0) saw_nz = 1;
      else if (saw_nz) wrapped = 1;
    end
    if (!reset && bus.start) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_start: got start with instr %h at pc %0d, required none",
                 bus.instruction, bus.pc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("start_instr", {32'b0, bus.instruction}, {32'b0, mon_e.word});
        if (mon_e.gap > 0) chk("start_gap", 64'(cyc - last_start), 64'(mon_e.gap));
        if (n_started > 0) chk("instr_hold", {63'b0, hold_bad}, 64'd0);
        $display("issue pc=%0d instr=%h cycle=%0d", bus.pc, bus.instruction, cyc);
        cur_word = mon_e.word;
      end
      hold_bad   = 0;
      last_start = cyc;
      n_started++;
    end else if (!reset && bus.busy && n_started > 0 && bus.instruction !== cur_word) begin
      hold_bad = 1;
    end
  end

  task automatic push(input logic [31:0] w, input int gap);
    exp_t e;
    e.word = w;
    e.gap  = gap;
    sb_q.push_back(e);
    last_word = w;
  endtask

  task automatic write_word(input int a, input logic [31:0] w);
    @(posedge clk); #1;
    bus.prog_we = 1'b1; bus.prog_addr = ADDR_W'(a); bus.prog_data = w;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
  endtask

  task automatic clear_run_state();
    n_started = 0; saw_nz = 0; wrapped = 0; hold_bad = 0;
  endtask

  task automatic start_run();
    clear_run_state();
    @(posedge clk); #1 bus.run = 1'b1;
    @(posedge clk); #1 bus.run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_delay, input logic exp_err,
                           input int exp_pc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20000);
    if (!bus.done) begin
      checks++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles, required done", tag, n);
      return;
    end
    if (exp_delay >= 0) chk({tag, "_done_delay"}, 64'(cyc - last_start), 64'(exp_delay));
    chk({tag, "_error"}, {63'b0, bus.error}, {63'b0, exp_err});
    chk({tag, "_pc"}, 64'(bus.pc), 64'(exp_pc));
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    if (n_started > 0) chk({tag, "_hold"}, {63'b0, hold_bad}, 64'd0);
    $display("done %s pc=%0d error=%0b starts=%0d cycle=%0d", tag, bus.pc, bus.error,
             n_started, cyc);
    @(negedge clk);
    chk({tag, "_busy_low"}, {63'b0, bus.busy}, 64'd0);
    chk({tag, "_done_pulse"}, {63'b0, bus.done}, 64'd0);
    chk({tag, "_instr_kept"}, {32'b0, bus.instruction}, {32'b0, last_word});
    sb_q.delete();
  endtask

  vec_t vecs[10];

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.run = 1'b0;
    vecs[0] = '{6'd0,  69,   1'b1};
    vecs[1] = '{6'd1,  69,   1'b1};
    vecs[2] = '{6'd9,  69,   1'b1};
    vecs[3] = '{6'd10, 69,   1'b1};
    vecs[4] = '{6'd5,  38,   1'b1};
    vecs[5] = '{6'd8,  38,   1'b1};
    vecs[6] = '{6'd7,  37,   1'b1};
    vecs[7] = '{6'd6,  0,    1'b0};
    vecs[8] = '{6'd3,  0,    1'b0};
    vecs[9] = '{6'd2,  2247, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_instr", {32'b0, bus.instruction}, 64'd0);
    chk("rst_start", {63'b0, bus.start}, 64'd0);
    chk("rst_busy",  {63'b0, bus.busy},  64'd0);
    chk("rst_done",  {63'b0, bus.done},  64'd0);
    chk("rst_error", {63'b0, bus.error}, 64'd0);
    chk("rst_pc",    64'(bus.pc),        64'd0);

    // Table: two instances of an opcode, then HALT.
    for (int i = 0; i < 10; i++) begin
      write_word(0, mk(vecs[i].op, 5'd1, 5'd2, 5'd3));
      write_word(1, mk(vecs[i].op, 5'd4, 5'd5, 5'd6));
      write_word(2, HALT);
      if (vecs[i].legal) begin
        push(mk(vecs[i].op, 5'd1, 5'd2, 5'd3), 0);
        push(mk(vecs[i].op, 5'd4, 5'd5, 5'd6), vecs[i].gap);
      end
      start_run();
      wait_done($sformatf("vec_op%0d", vecs[i].op), vecs[i].legal ? vecs[i].gap : -1,
                !vecs[i].legal, 2);
    end

    // Single op0 then HALT.
    write_word(0, mk(6'd0, 5'd1, 5'd2, 5'd3));
    write_word(1, HALT);
    push(32'h0022_1800, 0);
    start_run();
    wait_done("t1", 69, 1'b0, 1);

    // op5, op7, HALT; op7 written in the same cycle as run.
    write_word(0, mk(6'd5, 5'd3, 5'd4, 5'd5));
    write_word(1, 32'h0);
    write_word(2, HALT);
    push(mk(6'd5, 5'd3, 5'd4, 5'd5), 0);
    push(mk(6'd7, 5'd6, 5'd7, 5'd8), 38);
    clear_run_state();
    @(posedge clk); #1;
    bus.run = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = 6'd1;
    bus.prog_data = mk(6'd7, 5'd6, 5'd7, 5'd8);
    @(posedge clk); #1;
    bus.run = 1'b0; bus.prog_we = 1'b0;
    wait_done("t3", 37, 1'b0, 2);

    // Illegal opcode 3 skipped, op1 issued, error sticky.
    write_word(0, mk(6'd3, 5'd1, 5'd1, 5'd1));
    write_word(1, mk(6'd1, 5'd9, 5'd10, 5'd11));
    write_word(2, HALT);
    push(mk(6'd1, 5'd9, 5'd10, 5'd11), 0);
    start_run();
    wait_done("t4", 69, 1'b1, 2);
    repeat (5) @(negedge clk);
    chk("t4_error_sticky", {63'b0, bus.error}, 64'd1);

    // Reset in the middle of a multiply wait, then rerun.
    write_word(0, mk(6'd2, 5'd7, 5'd8, 5'd9));
    write_word(1, mk(6'd1, 5'd12, 5'd13, 5'd14));
    write_word(2, HALT);
    push(mk(6'd2, 5'd7, 5'd8, 5'd9), 0);
    start_run();
    @(negedge clk);
    chk("t5_run_clears_error", {63'b0, bus.error}, 64'd0);
    chk("t5_busy_after_run", {63'b0, bus.busy}, 64'd1);
    for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(negedge clk);
    chk("t5_mul_issued", 64'(sb_q.size()), 64'd0);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy",  {63'b0, bus.busy},  64'd0);
    chk("t5_rst_start", {63'b0, bus.start}, 64'd0);
    chk("t5_rst_pc",    64'(bus.pc),        64'd0);
    $display("reset mid-program busy=%0b start=%0b cycle=%0d", bus.busy, bus.start, cyc);
    sb_q.delete();
    last_word = '0;
    push(mk(6'd2, 5'd7, 5'd8, 5'd9), 0);
    push(mk(6'd1, 5'd12, 5'd13, 5'd14), 2247);
    start_run();
    wait_done("t5_rerun", 69, 1'b0, 2);

    // Full buffer of op1, no HALT; a write and a run while busy must be ignored.
    for (int a = 0; a < DEPTH; a++) begin
      write_word(a, mk(6'd1, 5'(a), 5'(a + 1), 5'(a + 2)));
      push(mk(6'd1, 5'(a), 5'(a + 1), 5'(a + 2)), (a == 0) ? 0 : 69);
    end
    start_run();
    repeat (700) @(posedge clk);
    write_word(40, HALT);
    @(posedge clk); #1 bus.run = 1'b1;
    @(posedge clk); #1 bus.run = 1'b0;
    wait_done("t6", 67, 1'b0, DEPTH - 1);
    chk("t6_starts", 64'(n_started), 64'(DEPTH));
    chk("t6_no_wrap", {63'b0, wrapped}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
